// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Holds the 640x480@60 default timing, derived totals and the window decode.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 11;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam logic        DEF_SYNC_POL = 1'b0;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // True when count lies in [start, start+width). One extra bit keeps the
  // upper bound from overflowing.
  function automatic logic in_window(input logic [COORD_W-1:0] count,
                                     input logic [COORD_W-1:0] start,
                                     input logic [COORD_W-1:0] width);
    logic [COORD_W:0] c;
    logic [COORD_W:0] lo;
    logic [COORD_W:0] hi;
    c  = {1'b0, count};
    lo = {1'b0, start};
    hi = lo + {1'b0, width};
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable, wrap flag, and decode of the
// sync window and active region for the value the counter is about to load.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap,
  output logic               sync_next,
  output logic               active_next
);

  localparam int unsigned        TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE + FP);
  localparam logic [COORD_W-1:0] SYNC_W     = COORD_W'(SYNC);
  localparam logic [COORD_W-1:0] ACT_END    = COORD_W'(ACTIVE);

  logic [COORD_W-1:0] cnt_q;
  logic [COORD_W-1:0] cnt_d;

  // Next count and the window decode of that next count.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cnt_d       = cnt_q;
    wrap        = (cnt_q == LAST);
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + COORD_W'(1);
    end
    sync_next   = in_window(cnt_d, SYNC_START, SYNC_W);
    active_next = (cnt_d < ACT_END);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: clock divider to pixel rate, horizontal and
// vertical counters, registered blank/sync decode and line/frame strobes.
// Optional feature macro VGA_SYNC_PIPE_EN delays blank/hsync/vsync by one
// pixel period to line up with the sprite stage's one-pixel ROM latency.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = DEF_SYNC_POL
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               pix_en,
  output logic [COORD_W-1:0] hc,
  output logic [COORD_W-1:0] vc,
  output logic               blank,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_d;
  logic       pix_en_q, pix_en_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       blank_q, blank_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  logic h_wrap, h_sync_next, h_active_next;
  logic v_wrap, v_sync_next, v_active_next;

  // Horizontal axis advances on every pixel strobe.
  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .en(pix_en_d),
    .cnt(hc), .wrap(h_wrap), .sync_next(h_sync_next), .active_next(h_active_next)
  );

  // Vertical axis advances only when the line wraps.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .en(pix_en_d & h_wrap),
    .cnt(vc), .wrap(v_wrap), .sync_next(v_sync_next), .active_next(v_active_next)
  );

  // Divider, strobes and decode of the next counter values.
  always_comb begin
    pix_en_d      = (div_q == DIV_LAST);
    div_d         = pix_en_d ? 4'd0 : div_q + 4'd1;
    line_start_d  = pix_en_d & h_wrap;
    frame_start_d = line_start_d & v_wrap;
    blank_d       = ~(h_active_next & v_active_next);
    hsync_d       = h_sync_next ? SYNC_POL : ~SYNC_POL;
    vsync_d       = v_sync_next ? SYNC_POL : ~SYNC_POL;
  end

  // Output and divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      blank_q       <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

`ifdef VGA_SYNC_PIPE_EN
  logic blank_p_q, blank_p_d;
  logic hsync_p_q, hsync_p_d;
  logic vsync_p_q, vsync_p_d;

  // Capture the aligned decode on each pixel strobe, giving one pixel of delay.
  always_comb begin
    blank_p_d = pix_en_d ? blank_q : blank_p_q;
    hsync_p_d = pix_en_d ? hsync_q : hsync_p_q;
    vsync_p_d = pix_en_d ? vsync_q : vsync_p_q;
  end

  // One-pixel delay registers for blank and sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_p_q <= 1'b0;
      hsync_p_q <= ~SYNC_POL;
      vsync_p_q <= ~SYNC_POL;
    end else begin
      blank_p_q <= blank_p_d;
      hsync_p_q <= hsync_p_d;
      vsync_p_q <= vsync_p_d;
    end
  end

  assign blank = blank_p_q;
  assign hsync = hsync_p_q;
  assign vsync = vsync_p_q;
`else
  assign blank = blank_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
`endif

  assign pix_en      = pix_en_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
